uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter between `NUM_REQ` byte producers, such as the free-running counter and status sources. It selects one pending requester by round-robin, captures its byte and acknowledges it. It then sequences two UART transfers: a header byte identifying the source, followed by the data byte. The block sits between the producers and the UART TX block and owns that block's `i_Tx_DV`/`i_Tx_Byte` inputs.

## Interface
- `NUM_REQ`, default 4: number of requesters. Legal range is 2..8.
- `HDR_TAG`, default 8'hA0: header base. The header is `HDR_TAG | {5'b0, id[2:0]}`.

- `i_Clk`  in  1  system clock; all logic is on the rising edge.
- `i_Rst`  in  1  reset; synchronous, active-high.
- `i_Req_DV`  in  NUM_REQ  per-requester byte valid. The requester holds it high until it is acked.
- `i_Req_Byte`  in  8*NUM_REQ  requester k's byte is in bits [8k+7:8k].
- `o_Req_Ack`  out  NUM_REQ  one-cycle pulse on the winner's bit when its byte is captured.
- `o_Tx_DV`  out  1  one-cycle start pulse to the UART TX.
- `o_Tx_Byte`  out  8  byte to send. Valid when `o_Tx_DV` is high, and held stable until the next pulse.
- `i_Tx_Active`  in  1  UART TX is busy.
- `i_Tx_Done`  in  1  UART TX one-cycle completion pulse.
- `o_Busy`  out  1  high in every state other than IDLE.
- `o_Grant_Id`  out  3  index of the current or most recent winner.

## Operation
- States: IDLE, HDR, WAIT_HDR, DATA, WAIT_DATA.
- **IDLE**
  - If `|i_Req_DV` and `!i_Tx_Active`:
    - Pick winner w = the first set bit searching from `ptr` upward, wrapping at NUM_REQ.
    - Latch `i_Req_Byte[w]` into the data register and w into `o_Grant_Id`.
    - Pulse `o_Req_Ack[w]`.
    - Set `ptr <= (w+1) mod NUM_REQ`.
    - Go to HDR.
  - Otherwise stay in IDLE. `i_Tx_Done` is ignored in IDLE.
- **HDR**: if `!i_Tx_Active`, assert `o_Tx_DV` with `o_Tx_Byte` = header and go to WAIT_HDR. Otherwise wait in HDR with `o_Tx_DV` = 0.
- **WAIT_HDR**: `o_Tx_DV` = 0. On `i_Tx_Done`, go to DATA.
- **DATA**: same as HDR, but sends the latched data byte, then goes to WAIT_DATA.
- **WAIT_DATA**: on `i_Tx_Done`, go to IDLE.
- Requests are sampled only in IDLE:
  - `i_Req_DV` changes outside IDLE have no effect.
  - A requester may drop DV before it is acked; it then loses its place with no side effects.
- A requester that is not acked is never starved. With all bits set, grants go in order 0,1,…,NUM_REQ-1,0.
- `ptr` advances only on a grant.
- The data register, `o_Tx_Byte` and `o_Grant_Id` are unchanged while no grant is in progress.

## Timing
- All outputs are registered.
- Reset values: `o_Req_Ack` = 0, `o_Tx_DV` = 0, `o_Tx_Byte` = 8'h00, `o_Busy` = 0, `o_Grant_Id` = 0, `ptr` = 0, state = IDLE.
- Arbitration and start latency:
  - On the edge where IDLE sees a request, `o_Req_Ack[w]` and `o_Busy` go high in the following cycle.
  - `o_Tx_DV` (header) is high in the cycle after that, provided `i_Tx_Active` is low.
  - Best case: request at cycle N gives ack at N+1 and header DV at N+2.
- Data DV: `o_Tx_DV` for the data byte is high in the cycle after `i_Tx_Done` for the header is sampled, provided `i_Tx_Active` is low.
- Completion: `o_Busy` falls in the cycle after `i_Tx_Done` for the data byte is sampled. A new arbitration can take place on that same edge, giving back-to-back frames.
- `o_Tx_DV` is never high for two consecutive cycles.
- `o_Req_Ack` is never high for more than one cycle, and at most one of its bits is set at a time.
- Reset mid-frame, in any state: the next cycle shows all reset values and `ptr` = 0. The frame in progress is abandoned with no further `o_Tx_DV`. An acked byte is lost.
- `i_Tx_Done` seen in HDR or DATA, i.e. before this block's DV, is ignored.

## Test plan
- **Reset**: hold `i_Rst` for 3 cycles with requests active → all outputs 0 throughout, and no ack.
- **Single frame**:
  - Stimulus: `i_Req_DV` = 4'b0100 with byte 0x5C; UART model is Active for 10 cycles and pulses Done 10 cycles after each DV.
  - Required: `o_Req_Ack` = 4'b0100 for 1 cycle; `o_Tx_DV` with 0xA2, then `o_Tx_DV` with 0x5C; `o_Grant_Id` = 2; `o_Busy` falls 1 cycle after the second Done.
- **Round-robin fairness**: all four requesters re-raise DV immediately after their ack → grant order 0,1,2,3,0,1 with headers 0xA0,0xA1,0xA2,0xA3.
- **Back-pressure**: `i_Tx_Active` held high for 20 cycles while `i_Req_DV` = 4'b0001 → no ack until the cycle after Active falls. Active raised during HDR → DV is delayed until Active falls.
- **Reset mid-frame**: assert reset in WAIT_DATA, then requests 4'b1010 → next grant is to requester 1 (`ptr` = 0), with no residual `o_Tx_DV`.
- **Spurious Done and requests withdrawn**:
  - Stimulus: pulse `i_Tx_Done` in IDLE, then raise and drop `i_Req_DV[3]` while Busy.
  - Required: no state change from the Done; requester 3 is not granted after the frame ends.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte
// producers, sending a source-tagged header byte followed by the captured data byte.
module uart_tx_arbiter #(
  parameter int         NUM_REQ = 4,
  parameter logic [7:0] HDR_TAG = 8'hA0
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic [NUM_REQ-1:0]   i_Req_DV,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ack,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy,
  output logic [2:0]           o_Grant_Id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WAIT_HDR,
    S_DATA,
    S_WAIT_DATA
  } state_t;

  localparam logic [3:0] NR = 4'(NUM_REQ);

  state_t               state_q, state_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [7:0]           data_q, data_d;
  logic [2:0]           grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 tx_dv_q, tx_dv_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 busy_q, busy_d;

  // Requests and bytes padded to the 8-requester maximum so a 3-bit id indexes them exactly.
  logic [7:0]           req_pad;
  logic [63:0]          byte_pad;
  logic [2:0]           cand_idx [NUM_REQ];
  logic [3:0]           cand_sum [NUM_REQ];
  logic [NUM_REQ-1:0]   cand_hit;
  logic                 win_found;
  logic [2:0]           win_idx;
  logic [7:0]           win_onehot;
  logic [7:0]           win_byte;
  logic [7:0]           hdr_byte;

  assign req_pad  = 8'(i_Req_DV);
  assign byte_pad = 64'(i_Req_Byte);

  // Candidate gi is the requester gi places after ptr, wrapping at NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_sum[gi] = {1'b0, ptr_q} + 4'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= NR) ? 3'(cand_sum[gi] - NR) : cand_sum[gi][2:0];
      assign cand_hit[gi] = req_pad[cand_idx[gi]];
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest pending one wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[i];
      end
    end
  end

  assign win_onehot = 8'd1 << win_idx;
  assign win_byte   = byte_pad[{win_idx, 3'b000} +: 8];
  assign hdr_byte   = HDR_TAG | {5'b0, grant_q};

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    grant_d   = grant_q;
    ack_d     = '0;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    case (state_q)
      S_IDLE: begin
        if (win_found && !i_Tx_Active) begin
          grant_d = win_idx;
          data_d  = win_byte;
          ack_d   = win_onehot[NUM_REQ-1:0];
          ptr_d   = ({1'b0, win_idx} == NR - 4'd1) ? 3'd0 : win_idx + 3'd1;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (!i_Tx_Active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = hdr_byte;
          state_d   = S_WAIT_HDR;
        end
      end
      S_WAIT_HDR: begin
        if (i_Tx_Done) state_d = S_DATA;
      end
      S_DATA: begin
        if (!i_Tx_Active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = data_q;
          state_d   = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (i_Tx_Done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= 3'd0;
      data_q    <= 8'h00;
      grant_q   <= 3'd0;
      ack_q     <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      data_q    <= data_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= busy_d;
    end
  end

  assign o_Req_Ack  = ack_q;
  assign o_Tx_DV    = tx_dv_q;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_Busy     = busy_q;
  assign o_Grant_Id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected acks and TX bytes,
// a monitor pops and compares them whenever the DUT pulses o_Req_Ack or o_Tx_DV.
module tb_uart_tx_arbiter;
  localparam int N      = 4;
  localparam int PERIOD = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_dv;
  logic [8*N-1:0] req_byte;
  logic [N-1:0]   req_ack;
  logic           tx_dv;
  logic [7:0]     tx_byte;
  logic           tx_active;
  logic           tx_done;
  logic           busy;
  logic [2:0]     grant_id;

  logic           force_active;
  logic           spur_done;
  logic           done_r;
  int             ucnt;
  longint         last_done_t;
  logic [N-1:0]   rearm;

  int             checks = 0;
  int             errors = 0;
  int             ack_seen = 0;
  logic [7:0]     exp_tx[$];
  int             exp_ack[$];

  always #(PERIOD/2) clk = ~clk;

  assign tx_active = (ucnt > 0) | force_active;
  assign tx_done   = done_r | spur_done;

  uart_tx_arbiter #(.NUM_REQ(N), .HDR_TAG(8'hA0)) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Req_DV   (req_dv),
    .i_Req_Byte (req_byte),
    .o_Req_Ack  (req_ack),
    .o_Tx_DV    (tx_dv),
    .o_Tx_Byte  (tx_byte),
    .i_Tx_Active(tx_active),
    .i_Tx_Done  (tx_done),
    .o_Busy     (busy),
    .o_Grant_Id (grant_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at t=%0t", name, $time);
  endtask

  task automatic push_frame(input int id, input logic [7:0] data);
    exp_ack.push_back(id);
    exp_tx.push_back(8'hA0 | 8'(id));
    exp_tx.push_back(data);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && exp_ack.size() == 0 && !busy) return;
    end
    fail_now({name, "_timeout"});
  endtask

  task automatic wait_busy(input logic level, input string name);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (busy == level) return;
    end
    fail_now({name, "_timeout"});
  endtask

  // UART model: busy for 10 cycles after each start pulse, then a one-cycle Done.
  initial begin
    ucnt = 0;
    done_r = 1'b0;
    last_done_t = 0;
    forever begin
      @(negedge clk);
      done_r = 1'b0;
      if (tx_dv) ucnt = 10;
      else if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) begin
          done_r = 1'b1;
          last_done_t = $time;
        end
      end
    end
  end

  // Requesters without rearm drop DV once acked.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++)
        if (req_ack[k] && !rearm[k]) req_dv[k] = 1'b0;
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic       prev_dv;
    logic       prev_ack;
    logic [7:0] e;
    int         id;
    prev_dv  = 1'b0;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_dv) begin
        check("tx_dv_gap", 32'(prev_dv), 0);
        if (exp_tx.size() == 0) fail_now($sformatf("tx_unexpected byte %0h", tx_byte));
        else begin
          e = exp_tx.pop_front();
          check("tx_byte", 32'(tx_byte), 32'(e));
          $display("tx byte %0h (expected %0h)", tx_byte, e);
        end
      end
      if (req_ack != '0) begin
        check("ack_pulse", 32'(prev_ack), 0);
        ack_seen++;
        if (exp_ack.size() == 0) fail_now($sformatf("ack_unexpected %0b", req_ack));
        else begin
          id = exp_ack.pop_front();
          check("ack_vec", 32'(req_ack), 32'(1) << id);
          check("grant_id", 32'(grant_id), 32'(id));
          $display("ack %0b grant %0d (expected id %0d)", req_ack, grant_id, id);
        end
      end
      prev_dv  = tx_dv;
      prev_ack = (req_ack != '0);
    end
  end

  initial begin
    #(200000 * PERIOD);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst          = 1'b1;
    req_dv       = 4'b1111;
    req_byte     = 32'h1313_1313;
    force_active = 1'b0;
    spur_done    = 1'b0;
    rearm        = '0;

    // Reset held with requests active.
    repeat (3) begin
      @(negedge clk);
      check("rst_ack", 32'(req_ack), 0);
      check("rst_dv", 32'(tx_dv), 0);
      check("rst_byte", 32'(tx_byte), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_grant", 32'(grant_id), 0);
    end
    rst    = 1'b0;
    req_dv = '0;
    @(negedge clk);
    check("post_rst_ack", 32'(req_ack), 0);

    // Single frame from requester 2.
    req_byte[23:16] = 8'h5C;
    push_frame(2, 8'h5C);
    req_dv = 4'b0100;
    wait_busy(1'b1, "single_busy_rise");
    wait_busy(1'b0, "single_busy_fall");
    check("single_busy_fall_lat", 32'($time - last_done_t), PERIOD);
    check("single_grant", 32'(grant_id), 2);
    wait_idle("single");

    // Round-robin fairness from ptr = 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rr_rst_grant", 32'(grant_id), 0);
    req_byte = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 6; k++) push_frame(k % 4, 8'h10 + 8'(k % 4));
    base   = ack_seen;
    rearm  = 4'b1111;
    req_dv = 4'b1111;
    for (int i = 0; i < 2000 && ack_seen < base + 6; i++) @(negedge clk);
    check("rr_acks", 32'(ack_seen - base), 6);
    req_dv = '0;
    rearm  = '0;
    wait_idle("rr");

    // Back-pressure before arbitration and during HDR.
    req_byte[7:0] = 8'hC3;
    force_active  = 1'b1;
    push_frame(0, 8'hC3);
    req_dv = 4'b0001;
    repeat (20) begin
      @(negedge clk);
      check("bp_no_ack", 32'(req_ack), 0);
    end
    force_active = 1'b0;
    @(negedge clk);
    check("bp_ack_after", 32'(req_ack), 4'b0001);
    force_active = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_hdr_hold", 32'(tx_dv), 0);
    end
    force_active = 1'b0;
    @(negedge clk);
    check("bp_hdr_dv", 32'(tx_dv), 1);
    wait_idle("bp");

    // Reset in WAIT_DATA, then requests 1010 must grant 1 first.
    req_byte[23:16] = 8'h77;
    push_frame(2, 8'h77);
    req_dv = 4'b0100;
    for (int i = 0; i < 1000 && exp_tx.size() != 0; i++) @(negedge clk);
    check("mid_data_sent", 32'(exp_tx.size()), 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_dv", 32'(tx_dv), 0);
    check("mid_rst_byte", 32'(tx_byte), 0);
    check("mid_rst_grant", 32'(grant_id), 0);
    rst = 1'b0;
    req_byte[15:8]  = 8'h31;
    req_byte[31:24] = 8'h33;
    push_frame(1, 8'h31);
    push_frame(3, 8'h33);
    req_dv = 4'b1010;
    wait_idle("mid");

    // Spurious Done in IDLE, then a withdrawn request from requester 3.
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("spur_busy", 32'(busy), 0);
      check("spur_dv", 32'(tx_dv), 0);
    end
    req_byte[7:0] = 8'h42;
    push_frame(0, 8'h42);
    req_dv[0] = 1'b1;
    wait_busy(1'b1, "wd_busy");
    req_dv[3] = 1'b1;
    repeat (3) @(negedge clk);
    req_dv[3] = 1'b0;
    wait_idle("wd");
    repeat (30) begin
      @(negedge clk);
      check("wd_no_grant", 32'(busy), 0);
    end

    check("queues_empty", 32'(exp_tx.size() + exp_ack.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
